// File: rtl/ahb_lite_regbus_bridge.sv
// AHB-Lite slave to simple register bus: one strobe cycle per transfer, waits for
// rb_ack/rb_err with an optional timeout, and returns the two-cycle AHB ERROR response.
module ahb_lite_regbus_bridge #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  aclk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic                  hwrite,
   input  logic [2:0]            hsize,
   input  logic [2:0]            hburst,
   input  logic [3:0]            hprot,
   input  logic                  hmastlock,
   input  logic [31:0]           hwdata,
   output logic [31:0]           hrdata,
   output logic                  hready,
   output logic                  hresp,
   output logic [ADDR_WIDTH-1:0] rb_addr,
   output logic [31:0]           rb_wdata,
   output logic [3:0]            rb_wstrb,
   output logic                  rb_wr,
   output logic                  rb_rd,
   input  logic [31:0]           rb_rdata,
   input  logic                  rb_ack,
   input  logic                  rb_err
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR1, ERR2} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          wr_q;
   logic          start, legal, busy, timed_out;
   logic [3:0]    strb_calc;

   logic unused;
   assign unused = ^{hburst, hprot, hmastlock, htrans[0]};

   always_comb begin
      legal     = 1'b0;
      strb_calc = '0;
      case (hsize)
         3'd0: begin
            legal     = 1'b1;
            strb_calc = 4'b0001 << haddr[1:0];
         end
         3'd1: begin
            legal     = ~haddr[0];
            strb_calc = 4'b0011 << {haddr[1], 1'b0};
         end
         3'd2: begin
            legal     = (haddr[1:0] == 2'b00);
            strb_calc = 4'b1111;
         end
         default: ;
      endcase
   end

   assign busy      = (state == REQ) || (state == WAIT);
   assign start     = ((state == IDLE) || (state == DONE) || (state == ERR2)) && htrans[1];
   // cnt holds the number of busy cycles already completed, so the last allowed one is TIMEOUT-1
   assign timed_out = (TIMEOUT > 0) && (cnt == CNT_LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, DONE, ERR2: begin
            if (htrans[1]) state_nxt = legal ? REQ : ERR1;
            else           state_nxt = IDLE;
         end
         REQ, WAIT: begin
            if (rb_err)         state_nxt = ERR1;
            else if (rb_ack)    state_nxt = DONE;
            else if (timed_out) state_nxt = ERR1;
            else                state_nxt = WAIT;
         end
         ERR1:    state_nxt = ERR2;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         wr_q     <= 1'b0;
         rb_addr  <= '0;
         rb_wstrb <= '0;
         hrdata   <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            rb_addr  <= haddr;
            wr_q     <= hwrite;
            rb_wstrb <= strb_calc;
            cnt      <= '0;
         end else if (busy && (TIMEOUT > 0)) begin
            cnt <= cnt + CW'(1);
         end
         if (busy && rb_ack && !rb_err && !wr_q)
            hrdata <= rb_rdata;
      end
   end

   assign rb_wr    = (state == REQ) && wr_q;
   assign rb_rd    = (state == REQ) && !wr_q;
   assign rb_wdata = hwdata;
   assign hready   = !(busy || (state == ERR1));
   assign hresp    = (state == ERR1) || (state == ERR2);

endmodule

// File: doc/ahb_lite_regbus_bridge.md
AHB_LITE_REGBUS_BRIDGE -- requirements
Module: ahb_lite_regbus_bridge

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the haddr and rb_addr width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum wait cycles for rb_ack or rb_err; 0 disables the timeout.
REQ-003 The block SHALL have a single clock domain; reset is synchronous and active-high.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- aclk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- haddr  in  ADDR_WIDTH  AHB address.
- htrans  in  2  AHB transfer type.
- hwrite  in  1  AHB write flag.
- hsize  in  3  AHB transfer size.
- hburst  in  3  ignored.
- hprot  in  4  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  32  AHB write data.
- hrdata  out  32  AHB read data.
- hready  out  1  AHB ready.
- hresp  out  1  AHB error response.
- rb_addr  out  ADDR_WIDTH  register-bus address.
- rb_wdata  out  32  register-bus write data.
- rb_wstrb  out  4  register-bus byte-lane enables.
- rb_wr  out  1  register-bus write strobe.
- rb_rd  out  1  register-bus read strobe.
- rb_rdata  in  32  register-bus read data.
- rb_ack  in  1  register-bus completion.
- rb_err  in  1  register-bus slave error.

Function
REQ-005 The FSM SHALL have exactly these states: IDLE, REQ, WAIT, DONE, ERR1, ERR2.
REQ-006 An address phase SHALL be accepted on a rising edge when hready=1 and htrans[1]=1 (NONSEQ/SEQ), in state IDLE, DONE or ERR2.
- Accepting registers haddr into rb_addr, hwrite and the computed rb_wstrb.
REQ-007 If hready=1 and htrans[1]=0 (IDLE/BUSY), the FSM SHALL go to IDLE with OKAY and issue no register-bus access.
REQ-008 The byte-lane enables SHALL be computed at address-phase acceptance:
- hsize=0: rb_wstrb = 1 << haddr[1:0].
- hsize=1: rb_wstrb = 0011 << (2*haddr[1]).
- hsize=2: rb_wstrb = 1111.
REQ-009 The following SHALL be illegal and go directly to ERR1 with no rb_wr or rb_rd pulse:
- hsize>2.
- hsize=1 with haddr[0]=1.
- hsize=2 with haddr[1:0]!=0.
REQ-010 A legal transfer SHALL enter REQ; in REQ, exactly one of rb_wr (write) or rb_rd (read) SHALL be high for exactly that one cycle.
REQ-011 rb_wdata SHALL equal hwdata combinationally; it is valid only while rb_wr=1.
REQ-012 hready SHALL be 0 in REQ, WAIT and ERR1, and 1 in IDLE, DONE and ERR2; hresp SHALL be 1 only in ERR1 and ERR2.
REQ-013 rb_ack=1 in REQ or WAIT with rb_err=0 SHALL go to DONE; on a read, rb_rdata SHALL be captured into hrdata on that edge.
REQ-014 rb_err=1 in REQ or WAIT SHALL go to ERR1; rb_err wins when rb_ack and rb_err are asserted in the same cycle.
REQ-015 REQ without ack or err SHALL go to WAIT; a wait counter SHALL count cycles from REQ.
- With TIMEOUT>0, reaching TIMEOUT cycles without ack or err SHALL go to ERR1.
- rb_ack or rb_err arriving later SHALL be ignored.
REQ-016 ERR1 SHALL always go to ERR2, giving the two-cycle AHB ERROR response; ERR2 and DONE SHALL behave as IDLE for acceptance (REQ-006/007).
REQ-017 Minimum latency SHALL be: address phase at edge N, strobe in cycle N+1, ack in N+1, hready=1 in N+2 (one wait state).
REQ-018 hrdata SHALL hold its last captured value outside DONE; it is not updated on writes or errors.

Reset
REQ-019 While reset=1 at a rising edge, the block SHALL enter IDLE with these outputs:
- hready=1, hresp=0, hrdata=0.
- rb_wr=0, rb_rd=0, rb_addr=0, rb_wstrb=0.
- wait counter = 0.
REQ-020 Reset asserted in REQ or WAIT SHALL abort the transfer; no strobe SHALL be issued after the reset edge, and a late rb_ack SHALL be ignored.

Verification
REQ-021 Word write to 0x10, hwdata=0xCAFEF00D, ack in the REQ cycle -> one rb_wr pulse, rb_addr=0x10, rb_wstrb=1111, rb_wdata=0xCAFEF00D; hready low exactly 1 cycle; hresp=0.
REQ-022 Byte read at 0x13, ack after 3 WAIT cycles with rb_rdata=0x11223344 -> rb_rd one pulse, rb_wstrb=1000, hrdata=0x11223344 in DONE, hready low 4 cycles.
REQ-023 Halfword at 0x21, and hsize=3 -> no strobe; hready,hresp = (0,1) then (1,1).
REQ-024 TIMEOUT=4, no ack -> ERR1 after 4 cycles, then ERR2; an rb_ack arriving one cycle later -> no effect.
REQ-025 rb_ack and rb_err asserted together -> ERROR response; back-to-back NONSEQ accepted in DONE -> second strobe in the next cycle.
REQ-026 Reset during WAIT -> IDLE next cycle, hready=1, no further strobes.
